// File: rtl/div_iter.sv
// div_iter: 32-bit iterative restoring divider, signed/unsigned, 35-cycle latency with flush.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        flush,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] s,
    output logic [31:0] r
);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] xo, yo, ay, qd, rem, q_fix, r_fix;
    logic        sg, sign_q, sign_r, yz;
    logic [32:0] trial;
    // trial subtract of the shifted partial remainder and sign fix-up of the final values
    always_comb begin
        trial = {rem, qd[31]} - {1'b0, ay};
        q_fix = sign_q ? -qd : qd;
        r_fix = sign_r ? -rem : rem;
    end
    // control FSM and datapath; qd holds the remaining dividend bits and collects quotient bits from the LSB
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            div_ready <= 1'b1;
            res_valid <= 1'b0;
            s         <= '0;
            r         <= '0;
            cnt       <= '0;
            xo        <= '0;
            yo        <= '0;
            ay        <= '0;
            qd        <= '0;
            rem       <= '0;
            sg        <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            yz        <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            div_ready <= 1'b1;
            res_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (div_valid) begin
                    xo        <= x;
                    yo        <= y;
                    sg        <= div_signed;
                    div_ready <= 1'b0;
                    state     <= PREP;
                end
                PREP: begin
                    qd     <= (sg && xo[31]) ? -xo : xo;
                    ay     <= (sg && yo[31]) ? -yo : yo;
                    sign_q <= sg & (xo[31] ^ yo[31]);
                    sign_r <= sg & xo[31];
                    yz     <= yo == '0;
                    rem    <= '0;
                    cnt    <= '0;
                    state  <= ITER;
                end
                ITER: begin
                    rem   <= trial[32] ? {rem[30:0], qd[31]} : trial[31:0];
                    qd    <= {qd[30:0], ~trial[32]};
                    cnt   <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
                    state <= (cnt == 6'd31) ? FIX : ITER;
                end
                FIX: begin
                    s     <= yz ? 32'hFFFF_FFFF : q_fix;
                    r     <= yz ? xo : r_fix;
                    state <= DONE;
                end
                DONE: if (!res_valid) begin
                    res_valid <= 1'b1;
                end else if (res_ready) begin
                    res_valid <= 1'b0;
                    div_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic        div_signed = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] s;
    logic [31:0] r;
    int          checks = 0;
    int          errors = 0;

    div_iter dut (
        .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_ready(div_ready),
        .div_signed(div_signed), .x(x), .y(y), .flush(flush), .res_valid(res_valid),
        .res_ready(res_ready), .s(s), .r(r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic sg);
        x = a;
        y = b;
        div_signed = sg;
        div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        div_signed = ~sg;
    endtask

    task automatic wait_res(output int n, output logic rdy_hi);
        n = 0;
        rdy_hi = 1'b0;
        while (!res_valid && n < 60) begin
            rdy_hi |= div_ready;
            tick();
            n++;
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            seen |= res_valid;
            tick();
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [31:0] es, input logic [31:0] er, input int stall);
        int   n;
        logic rdy_hi;
        start(a, b, sg);
        wait_res(n, rdy_hi);
        chk({tag, "_lat"}, 32'(n), 32'd35);
        chk({tag, "_busy"}, 32'(rdy_hi | div_ready), 32'd0);
        chk({tag, "_s"}, s, es);
        chk({tag, "_r"}, r, er);
        for (int i = 0; i < stall; i++) begin
            div_valid = 1'b1;
            x = $urandom;
            y = $urandom;
            tick();
            chk({tag, "_hold"}, {s ^ es, r ^ er}, 32'd0);
            chk({tag, "_hold_v"}, {30'd0, res_valid, div_ready}, 32'd2);
        end
        div_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_ack"}, {30'd0, res_valid, div_ready}, 32'd1);
    endtask

    initial begin
        int   n;
        logic rdy_hi;
        repeat (3) tick();
        chk("rst_hold", {28'd0, res_valid, div_ready, |s, |r}, 32'd4);
        resetn = 1'b1;
        tick();
        chk("rst_out", {28'd0, res_valid, div_ready, |s, |r}, 32'd4);

        run("u100_7",   32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         0);
        run("sm7_2",    32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run("s7_m2",    32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         0);
        run("sdz",      32'h1234_5678, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 0);
        run("udz",      32'h1234_5678, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
        run("sdz_neg",  32'hFFFF_FFF8, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 0);
        run("sovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         0);
        run("uovf",     32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 0);
        run("sm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 0);
        run("umax_1",   32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         0);
        run("umax_16",  32'hFFFF_FFFF, 32'd16,        1'b0, 32'h0FFF_FFFF, 32'd15,        0);
        run("u5_10",    32'd5,         32'd10,        1'b0, 32'd0,         32'd5,         0);
        run("sm1_2",    32'hFFFF_FFFF, 32'd2,         1'b1, 32'd0,         32'hFFFF_FFFF, 0);
        run("bp",       32'd1000,      32'd33,        1'b0, 32'd30,        32'd10,        10);
        run("bp_next",  32'd81,        32'd9,         1'b1, 32'd9,         32'd0,         0);

        start(32'd1000, 32'd3, 1'b0);
        repeat (11) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_iter", {30'd0, res_valid, div_ready}, 32'd1);
        quiet("flush_quiet", 40);
        run("after_flush", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0);

        flush = 1'b1;
        div_valid = 1'b1;
        x = 32'd50;
        y = 32'd5;
        tick();
        flush = 1'b0;
        div_valid = 1'b0;
        chk("flush_idle", {30'd0, res_valid, div_ready}, 32'd1);
        quiet("flush_idle_quiet", 40);

        start(32'd50, 32'd5, 1'b0);
        wait_res(n, rdy_hi);
        chk("done_lat", 32'(n), 32'd35);
        flush = 1'b1;
        res_ready = 1'b1;
        tick();
        flush = 1'b0;
        res_ready = 1'b0;
        chk("flush_done", {30'd0, res_valid, div_ready}, 32'd1);

        start(32'd77, 32'd7, 1'b0);
        repeat (20) tick();
        resetn = 1'b0;
        flush = 1'b1;
        div_valid = 1'b1;
        tick();
        resetn = 1'b1;
        flush = 1'b0;
        div_valid = 1'b0;
        chk("rst_mid", {28'd0, res_valid, div_ready, |s, |r}, 32'd4);
        quiet("rst_quiet", 40);
        run("after_rst", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
